// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// VendCreditFsm (module vend_credit_fsm)
//
// Single shared-credit vending controller. Coins add to one credit
// accumulator. The one-hot item selection picks a price from a packed price
// table. Once the credit covers the selected price the item is vended for
// one cycle. Any remaining credit is then paid back as a train of nickel
// pulses, one pulse per unit.
//
// Optional feature macro:
//   VEND_QUARTER_EN  - adds the quarter_in_i coin input (worth 5 units).
//
// Parameters:
//   NUM_ITEMS  number of items (width of item_sel_i / dispensed_item_o)
//   CREDIT_W   credit register width in nickel units (1 = 5c)
//   PRICES     packed price table; item i at [i*CREDIT_W +: CREDIT_W], >= 1
//
// Ports:
//   clock              clock
//   reset              synchronous, active-high reset
//   item_sel_i         one-hot item selection, sampled every cycle
//   nickel_in_i        one-cycle coin pulse, 1 unit
//   dime_in_i          one-cycle coin pulse, 2 units
//   quarter_in_i       one-cycle coin pulse, 5 units (VEND_QUARTER_EN only)
//   cancel_i           refund the full credit (honoured in COLLECT only)
//   dispense_o         one-cycle vend pulse
//   dispensed_item_o   one-hot item being vended while dispense_o is high
//   nickel_out_o       one pulse per nickel of change
//   coin_reject_o      registered pulse, the cycle after a coin was refused
//   busy_o             high while vending or paying change
//   credit_o           current credit in nickel units
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {6'd6, 6'd5, 6'd4, 6'd3}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ITEMS-1:0] item_sel_i,
  input  logic                 nickel_in_i,
  input  logic                 dime_in_i,
`ifdef VEND_QUARTER_EN
  input  logic                 quarter_in_i,
`endif
  input  logic                 cancel_i,
  output logic                 dispense_o,
  output logic [NUM_ITEMS-1:0] dispensed_item_o,
  output logic                 nickel_out_o,
  output logic                 coin_reject_o,
  output logic                 busy_o,
  output logic [CREDIT_W-1:0]  credit_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  // Coin values are held one bit wider than the credit so that the sum's
  // top bit directly flags an overflow instead of wrapping.
  localparam logic [CREDIT_W:0] VAL_NICKEL  = {{CREDIT_W{1'b0}}, 1'b1};
  localparam logic [CREDIT_W:0] VAL_DIME    = {{(CREDIT_W-1){1'b0}}, 2'b10};
  localparam logic [CREDIT_W:0] VAL_QUARTER = {{(CREDIT_W-2){1'b0}}, 3'b101};
  localparam logic [NUM_ITEMS-1:0] ONE_ITEM = {{(NUM_ITEMS-1){1'b0}}, 1'b1};
  localparam logic [CREDIT_W-1:0]  ONE_UNIT = {{(CREDIT_W-1){1'b0}}, 1'b1};

  // Registered state and output latches
  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [NUM_ITEMS-1:0]  item_q, item_d;
  logic                  dispense_q;
  logic [NUM_ITEMS-1:0]  dispItem_q;
  logic                  nickel_q;
  logic                  busy_q;
  logic                  reject_q, reject_d;

  // Combinational helpers
  logic [1:0]            coinCount;
  logic [CREDIT_W:0]     coinValue;
  logic [CREDIT_W:0]     creditSum;
  logic                  coinAny;
  logic                  coinFits;
  logic                  coinOk;
  logic                  selOneHot;
  logic [CREDIT_W-1:0]   selPrice;
  logic                  priceMet;

  // Coin decode: count how many coin lines are high this cycle and pick the
  // value of the coin when exactly one is present. With two or more coins
  // the value is irrelevant because all of them are refused.
  always_comb begin
    coinCount = 2'd0;
    coinValue = '0;
    if (nickel_in_i) begin
      coinCount = coinCount + 2'd1;
      coinValue = VAL_NICKEL;
    end
    if (dime_in_i) begin
      coinCount = coinCount + 2'd1;
      coinValue = VAL_DIME;
    end
`ifdef VEND_QUARTER_EN
    if (quarter_in_i) begin
      coinCount = (coinCount == 2'd2) ? 2'd2 : coinCount + 2'd1;
      coinValue = VAL_QUARTER;
    end
`else
    coinValue = coinValue | (VAL_QUARTER & '0);
`endif
    coinAny   = (coinCount != 2'd0);
    creditSum = {1'b0, credit_q} + coinValue;
    coinFits  = ~creditSum[CREDIT_W];
  end

  // Price lookup for the current selection. A zero or multi-hot selection
  // never counts as a met price, so credit just sits in COLLECT.
  always_comb begin
    selPrice  = '0;
    selOneHot = (item_sel_i != '0) &&
                ((item_sel_i & (item_sel_i - ONE_ITEM)) == '0);
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel_i[i]) begin
        selPrice = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    priceMet = selOneHot && (credit_q >= selPrice);
  end

  // A coin is only taken while collecting, alone, without a simultaneous
  // cancel, without overflowing, and only while more credit is still needed.
  always_comb begin
    coinOk = (coinCount == 2'd1) && coinFits && !cancel_i &&
             ((state_q == IDLE) || ((state_q == COLLECT) && !priceMet));
  end

  // Next-state logic. In COLLECT the priority is cancel, then vend, then
  // coin accept; a coin alongside a met price is already refused above, so
  // vend and accept can never both happen.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    reject_d = coinAny && !coinOk;
    unique case (state_q)
      IDLE: begin
        if (coinOk) begin
          credit_d = creditSum[CREDIT_W-1:0];
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel_i) begin
          state_d = CHANGE;
        end else if (priceMet) begin
          credit_d = credit_q - selPrice;
          item_d   = item_sel_i;
          state_d  = VEND;
        end else if (coinOk) begin
          credit_d = creditSum[CREDIT_W-1:0];
        end
      end
      VEND: begin
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        // Each cycle here is one nickel paid out; leaving on the last unit
        // gives exactly N pulses for N units of change.
        if (credit_q <= ONE_UNIT) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - ONE_UNIT;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  // The FSM register. Outputs are decoded from the next state and stored so
  // every output comes straight from a flop; a reset drops everything,
  // including any change still owed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      item_q     <= '0;
      dispense_q <= 1'b0;
      dispItem_q <= '0;
      nickel_q   <= 1'b0;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      dispense_q <= (state_d == VEND);
      dispItem_q <= (state_d == VEND) ? item_d : '0;
      nickel_q   <= (state_d == CHANGE);
      busy_q     <= (state_d == VEND) || (state_d == CHANGE);
      reject_q   <= reject_d;
    end
  end

  assign dispense_o       = dispense_q;
  assign dispensed_item_o = dispItem_q;
  assign nickel_out_o     = nickel_q;
  assign coin_reject_o    = reject_q;
  assign busy_o           = busy_q;
  assign credit_o         = credit_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// Testbench for vend_credit_fsm. A default-sized instance covers vending,
// change, cancel and reset; a 3-bit-credit instance sharing the same inputs
// covers the overflow rule. Quarter scenarios build only with
// VEND_QUARTER_EN.
// ---------------------------------------------------------------------------
module tb_vend_credit_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] itemSel = 4'b0000;
  logic       nickelIn = 1'b0;
  logic       dimeIn = 1'b0;
  logic       quarterIn = 1'b0;
  logic       cancel = 1'b0;

  logic       dispense;
  logic [3:0] dispensedItem;
  logic       nickelOut;
  logic       coinReject;
  logic       busy;
  logic [5:0] credit;

  logic       sDispense;
  logic [3:0] sDispensedItem;
  logic       sNickelOut;
  logic       sCoinReject;
  logic       sBusy;
  logic [2:0] sCredit;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  vend_credit_fsm dut (
    .clock            (clock),
    .reset            (reset),
    .item_sel_i       (itemSel),
    .nickel_in_i      (nickelIn),
    .dime_in_i        (dimeIn),
`ifdef VEND_QUARTER_EN
    .quarter_in_i     (quarterIn),
`endif
    .cancel_i         (cancel),
    .dispense_o       (dispense),
    .dispensed_item_o (dispensedItem),
    .nickel_out_o     (nickelOut),
    .coin_reject_o    (coinReject),
    .busy_o           (busy),
    .credit_o         (credit)
  );

  vend_credit_fsm #(
    .NUM_ITEMS (4),
    .CREDIT_W  (3),
    .PRICES    ({3'd6, 3'd5, 3'd4, 3'd3})
  ) dutSmall (
    .clock            (clock),
    .reset            (reset),
    .item_sel_i       (itemSel),
    .nickel_in_i      (nickelIn),
    .dime_in_i        (dimeIn),
`ifdef VEND_QUARTER_EN
    .quarter_in_i     (quarterIn),
`endif
    .cancel_i         (cancel),
    .dispense_o       (sDispense),
    .dispensed_item_o (sDispensedItem),
    .nickel_out_o     (sNickelOut),
    .coin_reject_o    (sCoinReject),
    .busy_o           (sBusy),
    .credit_o         (sCredit)
  );

  // Drive one cycle of inputs, let the rising edge take them, then settle
  // 1ns past the edge where outputs are sampled.
  task automatic applyStimulus(input logic [3:0] sel, input logic n,
                               input logic d, input logic q, input logic c);
    itemSel   = sel;
    nickelIn  = n;
    dimeIn    = d;
    quarterIn = q;
    cancel    = c;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({dispense, dispensedItem, nickelOut, coinReject, busy} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000000",
               {dispense, dispensedItem, nickelOut, coinReject, busy});
    end
    checks++;
    if (credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_credit: got %0d expected 0", credit);
    end
  endtask

  // Price 3: dime, idle, dime gives credit 4, vend, 1 nickel of change.
  task automatic test_vend_with_change();
    doReset();
    applyStimulus(4'b0001, 0, 1, 0, 0);
    checks++;
    if (credit !== 6'd2) begin
      errors++;
      $display("[TB] FAIL change_credit_dime1: got %0d expected 2", credit);
    end
    applyStimulus(4'b0001, 0, 0, 0, 0);
    checks++;
    if (credit !== 6'd2 || dispense !== 1'b0) begin
      errors++;
      $display("[TB] FAIL change_idle_hold: got credit=%0d dispense=%b expected 2/0",
               credit, dispense);
    end
    applyStimulus(4'b0001, 0, 1, 0, 0);
    checks++;
    if (credit !== 6'd4) begin
      errors++;
      $display("[TB] FAIL change_credit_dime2: got %0d expected 4", credit);
    end
    applyStimulus(4'b0001, 0, 0, 0, 0);
    checks++;
    if (dispense !== 1'b1 || dispensedItem !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL change_vend: got dispense=%b item=%b busy=%b expected 1/0001/1",
               dispense, dispensedItem, busy);
    end
    checks++;
    if (credit !== 6'd1) begin
      errors++;
      $display("[TB] FAIL change_credit_after_vend: got %0d expected 1", credit);
    end
    applyStimulus(4'b0001, 0, 0, 0, 0);
    checks++;
    if (nickelOut !== 1'b1 || dispense !== 1'b0 || dispensedItem !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL change_nickel: got nickel=%b dispense=%b item=%b expected 1/0/0000",
               nickelOut, dispense, dispensedItem);
    end
    applyStimulus(4'b0001, 0, 0, 0, 0);
    checks++;
    if (nickelOut !== 1'b0 || busy !== 1'b0 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL change_done: got nickel=%b busy=%b credit=%0d expected 0/0/0",
               nickelOut, busy, credit);
    end
  endtask

  // Price 6 paid exactly by three dimes; a coin during VEND is refused.
  task automatic test_exact_vend();
    doReset();
    applyStimulus(4'b1000, 0, 1, 0, 0);
    applyStimulus(4'b1000, 0, 1, 0, 0);
    applyStimulus(4'b1000, 0, 1, 0, 0);
    checks++;
    if (credit !== 6'd6 || dispense !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exact_credit: got credit=%0d dispense=%b expected 6/0",
               credit, dispense);
    end
    applyStimulus(4'b1000, 0, 0, 0, 0);
    checks++;
    if (dispense !== 1'b1 || dispensedItem !== 4'b1000 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL exact_vend: got dispense=%b item=%b credit=%0d expected 1/1000/0",
               dispense, dispensedItem, credit);
    end
    applyStimulus(4'b1000, 1, 0, 0, 0);
    checks++;
    if (coinReject !== 1'b1 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL vend_coin_reject: got reject=%b credit=%0d expected 1/0",
               coinReject, credit);
    end
    checks++;
    if (busy !== 1'b0 || nickelOut !== 1'b0 || dispense !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exact_idle: got busy=%b nickel=%b dispense=%b expected 0/0/0",
               busy, nickelOut, dispense);
    end
    applyStimulus(4'b1000, 0, 0, 0, 0);
    checks++;
    if (coinReject !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reject_one_cycle: got %b expected 0", coinReject);
    end
  endtask

  task automatic test_multi_coin();
    doReset();
    applyStimulus(4'b0000, 1, 1, 0, 0);
    checks++;
    if (coinReject !== 1'b1 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL multi_coin: got reject=%b credit=%0d expected 1/0",
               coinReject, credit);
    end
  endtask

  // Credit 3 with no selection, cancel with a dime in the same cycle:
  // the dime is refused and exactly 3 nickels come back.
  task automatic test_cancel();
    int pulses = 0;
    int vends = 0;
    doReset();
    applyStimulus(4'b0000, 1, 0, 0, 0);
    applyStimulus(4'b0000, 0, 1, 0, 0);
    checks++;
    if (credit !== 6'd3) begin
      errors++;
      $display("[TB] FAIL cancel_credit: got %0d expected 3", credit);
    end
    applyStimulus(4'b0000, 0, 1, 0, 1);
    checks++;
    if (coinReject !== 1'b1 || credit !== 6'd3 || nickelOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cancel_entry: got reject=%b credit=%0d nickel=%b expected 1/3/1",
               coinReject, credit, nickelOut);
    end
    if (nickelOut) pulses++;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0000, 0, 0, 0, 0);
      if (nickelOut) pulses++;
      if (dispense) vends++;
      if (!busy) break;
    end
    checks++;
    if (pulses != 3 || vends != 0) begin
      errors++;
      $display("[TB] FAIL cancel_refund: got pulses=%0d vends=%0d expected 3/0",
               pulses, vends);
    end
    checks++;
    if (busy !== 1'b0 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL cancel_done: got busy=%b credit=%0d expected 0/0", busy, credit);
    end
    applyStimulus(4'b0000, 0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0 || nickelOut !== 1'b0 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL cancel_in_idle: got busy=%b nickel=%b credit=%0d expected 0/0/0",
               busy, nickelOut, credit);
    end
  endtask

  // Price 3 already met when cancel arrives: the refund beats the vend.
  task automatic test_cancel_wins();
    doReset();
    applyStimulus(4'b0001, 1, 0, 0, 0);
    applyStimulus(4'b0001, 0, 1, 0, 0);
    applyStimulus(4'b0001, 0, 0, 0, 1);
    checks++;
    if (dispense !== 1'b0 || nickelOut !== 1'b1 || credit !== 6'd3) begin
      errors++;
      $display("[TB] FAIL cancel_wins: got dispense=%b nickel=%b credit=%0d expected 0/1/3",
               dispense, nickelOut, credit);
    end
  endtask

  // Multi-hot selection holds credit; switching to one-hot vends at once.
  task automatic test_select();
    doReset();
    applyStimulus(4'b1100, 0, 1, 0, 0);
    applyStimulus(4'b1100, 0, 1, 0, 0);
    applyStimulus(4'b1100, 0, 1, 0, 0);
    applyStimulus(4'b1100, 0, 0, 0, 0);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checks++;
    if (dispense !== 1'b0 || busy !== 1'b0 || credit !== 6'd6) begin
      errors++;
      $display("[TB] FAIL not_onehot_hold: got dispense=%b busy=%b credit=%0d expected 0/0/6",
               dispense, busy, credit);
    end
    applyStimulus(4'b0100, 0, 0, 0, 0);
    checks++;
    if (dispense !== 1'b1 || dispensedItem !== 4'b0100 || credit !== 6'd1) begin
      errors++;
      $display("[TB] FAIL select_price5: got dispense=%b item=%b credit=%0d expected 1/0100/1",
               dispense, dispensedItem, credit);
    end
  endtask

  // Reset in the second change cycle drops the remaining refund.
  task automatic test_reset_in_change();
    int late = 0;
    doReset();
    applyStimulus(4'b0000, 0, 1, 0, 0);
    applyStimulus(4'b0000, 1, 0, 0, 0);
    applyStimulus(4'b0000, 0, 0, 0, 1);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checks++;
    if (nickelOut !== 1'b1 || credit !== 6'd2) begin
      errors++;
      $display("[TB] FAIL change_cycle2: got nickel=%b credit=%0d expected 1/2",
               nickelOut, credit);
    end
    reset = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    reset = 1'b0;
    checks++;
    if ({dispense, dispensedItem, nickelOut, coinReject, busy} !== 8'h00 ||
        credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_change: got outs=%b credit=%0d expected 00000000/0",
               {dispense, dispensedItem, nickelOut, coinReject, busy}, credit);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 0, 0, 0, 0);
      if (nickelOut) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("[TB] FAIL no_pulse_after_reset: got %0d pulses expected 0", late);
    end
  endtask

  // 3-bit credit: 6 + dime would be 8 > 7, so refused; a nickel fits to 7.
  task automatic test_overflow();
    doReset();
    applyStimulus(4'b0000, 0, 1, 0, 0);
    applyStimulus(4'b0000, 0, 1, 0, 0);
    applyStimulus(4'b0000, 0, 1, 0, 0);
    applyStimulus(4'b0000, 0, 1, 0, 0);
    checks++;
    if (sCoinReject !== 1'b1 || sCredit !== 3'd6) begin
      errors++;
      $display("[TB] FAIL overflow_dime: got reject=%b credit=%0d expected 1/6",
               sCoinReject, sCredit);
    end
    applyStimulus(4'b0000, 1, 0, 0, 0);
    checks++;
    if (sCoinReject !== 1'b0 || sCredit !== 3'd7) begin
      errors++;
      $display("[TB] FAIL overflow_fill: got reject=%b credit=%0d expected 0/7",
               sCoinReject, sCredit);
    end
    applyStimulus(4'b0000, 1, 0, 0, 0);
    checks++;
    if (sCoinReject !== 1'b1 || sCredit !== 3'd7) begin
      errors++;
      $display("[TB] FAIL overflow_full: got reject=%b credit=%0d expected 1/7",
               sCoinReject, sCredit);
    end
  endtask

`ifdef VEND_QUARTER_EN
  task automatic test_quarter();
    doReset();
    applyStimulus(4'b0000, 0, 0, 1, 0);
    checks++;
    if (sCredit !== 3'd5 || credit !== 6'd5) begin
      errors++;
      $display("[TB] FAIL quarter_accept: got small=%0d wide=%0d expected 5/5",
               sCredit, credit);
    end
    applyStimulus(4'b0000, 0, 0, 1, 0);
    checks++;
    if (sCoinReject !== 1'b1 || sCredit !== 3'd5) begin
      errors++;
      $display("[TB] FAIL quarter_overflow: got reject=%b credit=%0d expected 1/5",
               sCoinReject, sCredit);
    end
    checks++;
    if (coinReject !== 1'b0 || credit !== 6'd10) begin
      errors++;
      $display("[TB] FAIL quarter_wide: got reject=%b credit=%0d expected 0/10",
               coinReject, credit);
    end
  endtask
`endif

  initial begin
    $display("[TB] vend_credit_fsm bench start");
    test_reset();
    test_vend_with_change();
    test_exact_vend();
    test_multi_coin();
    test_cancel();
    test_cancel_wins();
    test_select();
    test_reset_in_change();
    test_overflow();
`ifdef VEND_QUARTER_EN
    test_quarter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
